// File: rtl/key_search_ctrl.sv
// key_search_ctrl: brute-force key sequencer for the arcfour core.
// Steps key_reg through [KEY_START, KEY_END]. For each key it launches the core,
// waits for core_finished, then streams the decrypted message out of the RAM.
// It stops on the first key whose plaintext is only lowercase letters and spaces,
// or when the range runs out. Every output is a flop. Next-state values are
// computed in one combinational process and loaded together, so the flags change
// in the same cycle that the state is entered.
module key_search_ctrl #(
  parameter int unsigned      KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter logic [KEY_W-1:0] KEY_END   = 24'h3FFFFF,
  parameter int unsigned      MSG_LEN   = 32,
  parameter int unsigned      ADDR_W    = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_go,
  output logic [KEY_W-1:0]  o_core_key,
  output logic              o_core_start,
  input  logic              i_core_finished,
  output logic [ADDR_W-1:0] o_msg_addr,
  input  logic [7:0]        i_msg_data,
  output logic              o_busy,
  output logic              o_found,
  output logic              o_exhausted,
  output logic [KEY_W-1:0]  o_found_key
);

  // Last legal RAM address. The scan counter runs one past it, because the final
  // byte is only checked in the cycle after its address is issued.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
  localparam logic [ADDR_W:0]   SCAN_LAST = (ADDR_W + 1)'(MSG_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_CORE,
    S_SCAN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [KEY_W-1:0]  r_key;
  logic [KEY_W-1:0]  w_key_next;
  logic              r_core_start;
  logic              w_core_start_next;
  logic [ADDR_W-1:0] r_msg_addr;
  logic [ADDR_W-1:0] w_msg_addr_next;
  logic [ADDR_W:0]   r_scan_cnt;
  logic [ADDR_W:0]   w_scan_cnt_next;
  logic              r_busy;
  logic              w_busy_next;
  logic              r_found;
  logic              w_found_next;
  logic              r_exhausted;
  logic              w_exhausted_next;
  logic [KEY_W-1:0]  r_found_key;
  logic [KEY_W-1:0]  w_found_key_next;

  logic              w_byte_ok;
  logic              w_byte_checked;

  // Plaintext alphabet: space or 'a'..'z'. The neighbours 8'h60 and 8'h7B are rejected.
  assign w_byte_ok = (i_msg_data == 8'h20) ||
                     ((i_msg_data >= 8'h61) && (i_msg_data <= 8'h7A));

  // The RAM has one cycle of read latency. Scan cycle 0 only issues address 0;
  // every later scan cycle sees the byte for the previous address.
  assign w_byte_checked = (r_scan_cnt != '0);

  // State register. An asynchronous reset returns to IDLE from any state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-output logic. Defaults hold every register.
  always_comb begin
    w_state_next     = r_state;
    w_key_next       = r_key;
    w_msg_addr_next  = r_msg_addr;
    w_scan_cnt_next  = r_scan_cnt;
    w_found_next     = r_found;
    w_exhausted_next = r_exhausted;
    w_found_key_next = r_found_key;

    case (r_state)
      S_IDLE, S_DONE: begin
        // go is only looked at here. A restart from DONE behaves like a start from IDLE.
        if (i_go) begin
          w_state_next     = S_LAUNCH;
          w_key_next       = KEY_START;
          w_found_next     = 1'b0;
          w_exhausted_next = 1'b0;
        end
      end

      S_LAUNCH: begin
        // Unconditional. An early core_finished cannot shorten the start pulse.
        w_state_next = S_WAIT_CORE;
      end

      S_WAIT_CORE: begin
        if (i_core_finished) begin
          w_state_next    = S_SCAN;
          w_scan_cnt_next = '0;
          w_msg_addr_next = '0;
        end
      end

      S_SCAN: begin
        if (w_byte_checked && !w_byte_ok) begin
          // Early abort. The address register freezes, so no further reads are issued.
          w_state_next = S_NEXT;
        end else if (r_scan_cnt == SCAN_LAST) begin
          // The last byte checked clean, so this key is the answer.
          w_state_next     = S_DONE;
          w_found_next     = 1'b1;
          w_found_key_next = r_key;
        end else begin
          w_scan_cnt_next = r_scan_cnt + 1'b1;
          // The address saturates at the last byte while that byte is still in flight.
          if (r_msg_addr != LAST_ADDR) begin
            w_msg_addr_next = r_msg_addr + 1'b1;
          end
        end
      end

      S_NEXT: begin
        if (r_key == KEY_END) begin
          w_state_next     = S_DONE;
          w_exhausted_next = 1'b1;
        end else begin
          w_key_next   = r_key + 1'b1;
          w_state_next = S_LAUNCH;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // These are decoded from the next state, so the registered outputs line up with state entry.
    w_core_start_next = (w_state_next == S_LAUNCH) || (w_state_next == S_WAIT_CORE);
    w_busy_next       = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
  end

  // Output and datapath registers. Reset clears core_start immediately, without waiting for a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key        <= KEY_START;
      r_core_start <= 1'b0;
      r_msg_addr   <= '0;
      r_scan_cnt   <= '0;
      r_busy       <= 1'b0;
      r_found      <= 1'b0;
      r_exhausted  <= 1'b0;
      r_found_key  <= '0;
    end else begin
      r_key        <= w_key_next;
      r_core_start <= w_core_start_next;
      r_msg_addr   <= w_msg_addr_next;
      r_scan_cnt   <= w_scan_cnt_next;
      r_busy       <= w_busy_next;
      r_found      <= w_found_next;
      r_exhausted  <= w_exhausted_next;
      r_found_key  <= w_found_key_next;
    end
  end

  assign o_core_key   = r_key;
  assign o_core_start = r_core_start;
  assign o_msg_addr   = r_msg_addr;
  assign o_busy       = r_busy;
  assign o_found      = r_found;
  assign o_exhausted  = r_exhausted;
  assign o_found_key  = r_found_key;

endmodule
